// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   - forwarding-select encodings driven onto fwd_a / fwd_b
//   - mul/div scheduler state encoding
//   - zero-register constant and the register-match / forward-select helpers
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  // $0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] x, input logic [4:0] d);
    return (x == d) && (d != ZERO_REG);
  endfunction

  // EX wins over MEM so the youngest producer is forwarded. A load in EX cannot
  // be forwarded at all; that case is handled by the load-use stall.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       ewreg,
                                         input logic       em2reg,
                                         input logic [4:0] edest,
                                         input logic       mwreg,
                                         input logic       mm2reg,
                                         input logic [4:0] mdest);
    if (ewreg && !em2reg && reg_match(src, edest)) return FWD_EXALU;
    if (mwreg && mm2reg && reg_match(src, mdest))  return FWD_MEMLD;
    if (mwreg && reg_match(src, mdest))            return FWD_MEMALU;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/md_sched.sv
// Mul/div unit scheduler: tracks occupancy of the shared multi-cycle unit.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   i_start   - an instruction issues to the unit this cycle
//   o_busy    - unit occupied (registered), spans exactly MD_CYCLES cycles
//   o_done    - registered pulse in the final busy cycle
module md_sched
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_busy,
  output logic o_done
);

  // Loading MD_CYCLES-1 and leaving BUSY after the zero count gives MD_CYCLES busy cycles.
  localparam logic [5:0] LOAD_VAL = 6'(MD_CYCLES - 1);

  md_state_e  r_state;
  logic [5:0] r_cnt;
  logic       r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= 6'd0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_state <= MD_BUSY;
            r_cnt   <= LOAD_VAL;
            r_done  <= (LOAD_VAL == 6'd0);
          end
        end
        MD_BUSY: begin
          // Counts regardless of pipeline freeze; the unit is free-running once issued.
          if (r_cnt == 6'd0) begin
            r_state <= MD_IDLE;
            r_done  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt - 6'd1;
            r_done <= (r_cnt == 6'd1);
          end
        end
        default: begin
          r_state <= MD_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = (r_state == MD_BUSY);
  assign o_done = r_done;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage integer pipeline.
// Drives PC / pipeline-register enables, the ID/EX bubble and IF/ID flush,
// ID-stage forwarding selects, and schedules the shared mul/div unit.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   id_*                         - fields of the instruction currently in ID
//   ewreg/em2reg/edest           - EX-stage write, load flag, destination
//   mwreg/mm2reg/mdest           - MEM-stage write, load flag, destination
//   mem_wait                     - data memory not ready; freezes all stages
//   pc_we, ifid_we, exmem_we, memwb_we, idex_bubble, ifid_flush - stage controls
//   fwd_a, fwd_b                 - rs / rt operand selects
//   md_busy, md_done             - mul/div occupancy and final-cycle pulse
//   stall_cnt                    - saturating count of cycles with pc_we=0
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_md_start,
  input  logic             id_use_hilo,
  input  logic             id_br_taken,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       edest,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mdest,
  input  logic             mem_wait,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  logic w_lu_stall;
  logic w_md_stall;
  logic w_front_stall;
  logic w_md_issue;

  assign w_lu_stall = ewreg & em2reg &
                      ((id_use_rs & reg_match(id_rs, edest)) |
                       (id_use_rt & reg_match(id_rt, edest)));
  // md_busy stays high through the done cycle, so dependents issue the cycle after.
  assign w_md_stall    = md_busy & (id_md_start | id_use_hilo);
  assign w_front_stall = w_lu_stall | w_md_stall;
  assign w_md_issue    = id_md_start & ~w_front_stall & ~mem_wait;

  md_sched #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md_sched (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_md_issue),
    .o_busy  (md_busy),
    .o_done  (md_done)
  );

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    fwd_a       = fwd_sel(id_rs, ewreg, em2reg, edest, mwreg, mm2reg, mdest);
    fwd_b       = fwd_sel(id_rt, ewreg, em2reg, edest, mwreg, mm2reg, mdest);
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
    end else if (mem_wait) begin
      // Freeze: nothing moves, and no bubble/flush may overwrite held state.
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (w_front_stall) begin
      // A stalled branch stays in ID and is re-evaluated next cycle.
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush = id_br_taken;
    end
  end

  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!pc_we && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MD_CYCLES=4 and a 4-bit stall counter.
module tb_hazard_stall_ctrl;

  localparam int unsigned MdCycles = 4;
  localparam int unsigned CntW     = 4;

  logic            clk;
  logic            rst;
  logic [4:0]      id_rs, id_rt, edest, mdest;
  logic            id_use_rs, id_use_rt, id_md_start, id_use_hilo, id_br_taken;
  logic            ewreg, em2reg, mwreg, mm2reg, mem_wait;
  logic            pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we;
  logic [1:0]      fwd_a, fwd_b;
  logic            md_busy, md_done;
  logic [CntW-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_stall_ctrl #(
    .MD_CYCLES (MdCycles),
    .CNT_W     (CntW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_md_start (id_md_start),
    .id_use_hilo (id_use_hilo),
    .id_br_taken (id_br_taken),
    .ewreg       (ewreg),
    .em2reg      (em2reg),
    .edest       (edest),
    .mwreg       (mwreg),
    .mm2reg      (mm2reg),
    .mdest       (mdest),
    .mem_wait    (mem_wait),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .exmem_we    (exmem_we),
    .memwb_we    (memwb_we),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_md_start = 1'b0; id_use_hilo = 1'b0; id_br_taken = 1'b0;
    ewreg = 1'b0; em2reg = 1'b0; edest = 5'd0;
    mwreg = 1'b0; mm2reg = 1'b0; mdest = 5'd0; mem_wait = 1'b0;
  endtask

  // Full set of stage controls in one call: pc, ifid, exmem, memwb, bubble, flush.
  task automatic check_ctl(input string tag, input logic [5:0] exp);
    check_eq({tag, ".ctl"}, {26'd0, pc_we, ifid_we, exmem_we, memwb_we, idex_bubble,
                             ifid_flush}, {26'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();
    // Forwarding conditions present during reset must still read as regfile.
    ewreg = 1'b1; edest = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1; id_br_taken = 1'b1;
    #1;
    check_ctl("rst", 6'b0000_11);
    check_eq("rst.fwd_a", 32'(fwd_a), 32'd0);
    check_eq("rst.fwd_b", 32'(fwd_b), 32'd0);
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    check_eq("post_rst.md_busy", 32'(md_busy), 32'd0);
    check_eq("post_rst.md_done", 32'(md_done), 32'd0);
    check_eq("post_rst.stall_cnt", 32'(stall_cnt), 32'd0);
    check_ctl("post_rst", 6'b1111_00);
    tick();

    // Load-use on rs with a taken branch in ID: stall wins, no flush.
    ewreg = 1'b1; em2reg = 1'b1; edest = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    id_br_taken = 1'b1;
    #1;
    check_ctl("lu_rs", 6'b0011_10);
    check_eq("lu_rs.fwd_a", 32'(fwd_a), 32'd0);
    tick();
    // Load now in MEM: forward load data, branch now flushes.
    ewreg = 1'b0; em2reg = 1'b0; edest = 5'd0; mwreg = 1'b1; mm2reg = 1'b1; mdest = 5'd5;
    #1;
    check_eq("lu_mem.fwd_a", 32'(fwd_a), 32'd3);
    check_ctl("lu_mem", 6'b1111_01);
    check_eq("lu_mem.stall_cnt", 32'(stall_cnt), 32'd1);
    tick();

    // EX and MEM both write $3: EX wins.
    clear_inputs();
    ewreg = 1'b1; edest = 5'd3; mwreg = 1'b1; mdest = 5'd3;
    id_rs = 5'd3; id_rt = 5'd3; id_use_rs = 1'b1; id_use_rt = 1'b1;
    #1;
    check_eq("fwd_ex.a", 32'(fwd_a), 32'd1);
    check_eq("fwd_ex.b", 32'(fwd_b), 32'd1);
    tick();
    ewreg = 1'b0;
    #1;
    check_eq("fwd_mem.a", 32'(fwd_a), 32'd2);
    check_eq("fwd_mem.b", 32'(fwd_b), 32'd2);
    tick();
    // $0 never forwards or stalls, even with a load in EX.
    ewreg = 1'b1; em2reg = 1'b1; edest = 5'd0; mdest = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    check_eq("zero.fwd_a", 32'(fwd_a), 32'd0);
    check_eq("zero.fwd_b", 32'(fwd_b), 32'd0);
    check_eq("zero.pc_we", 32'(pc_we), 32'd1);
    tick();
    // Load-use on rt only.
    clear_inputs();
    ewreg = 1'b1; em2reg = 1'b1; edest = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1;
    #1;
    check_ctl("lu_rt", 6'b0011_10);
    tick();
    clear_inputs();
    #1;
    check_eq("lu_rt.stall_cnt", 32'(stall_cnt), 32'd2);

    // DIV issues, MFLO waits 4 cycles.
    id_md_start = 1'b1;
    #1;
    check_eq("div_issue.pc_we", 32'(pc_we), 32'd1);
    check_eq("div_issue.md_busy", 32'(md_busy), 32'd0);
    tick();
    clear_inputs();
    id_use_hilo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("mflo%0d.md_busy", i), 32'(md_busy), 32'd1);
      check_eq($sformatf("mflo%0d.md_done", i), 32'(md_done), (i == 3) ? 32'd1 : 32'd0);
      check_ctl($sformatf("mflo%0d", i), 6'b0011_10);
      tick();
    end
    #1;
    check_eq("mflo_go.md_busy", 32'(md_busy), 32'd0);
    check_eq("mflo_go.md_done", 32'(md_done), 32'd0);
    check_eq("mflo_go.pc_we", 32'(pc_we), 32'd1);
    check_eq("mflo_go.stall_cnt", 32'(stall_cnt), 32'd6);
    tick();

    // mem_wait during BUSY: freeze beats md_stall; counter keeps running.
    clear_inputs();
    id_md_start = 1'b1;
    tick();
    clear_inputs();
    mem_wait = 1'b1; id_use_hilo = 1'b1; id_br_taken = 1'b1;
    #1;
    check_ctl("frz1", 6'b0000_00);
    check_eq("frz1.md_busy", 32'(md_busy), 32'd1);
    tick();
    id_use_hilo = 1'b0; id_br_taken = 1'b0;
    #1;
    check_eq("frz2.md_done", 32'(md_done), 32'd0);
    tick();
    #1;
    check_eq("frz3.md_busy", 32'(md_busy), 32'd1);
    check_eq("frz3.md_done", 32'(md_done), 32'd0);
    tick();
    mem_wait = 1'b0;
    #1;
    check_eq("frz4.md_busy", 32'(md_busy), 32'd1);
    check_eq("frz4.md_done", 32'(md_done), 32'd1);
    check_ctl("frz4", 6'b1111_00);
    tick();
    #1;
    check_eq("frz_end.md_busy", 32'(md_busy), 32'd0);
    check_eq("frz_end.stall_cnt", 32'(stall_cnt), 32'd9);

    // Saturation: 8 more stall cycles from 9 must stick at 15, not wrap to 1.
    mem_wait = 1'b1;
    repeat (8) tick();
    mem_wait = 1'b0;
    #1;
    check_eq("sat.stall_cnt", 32'(stall_cnt), 32'd15);
    tick();

    // Reset in the 2nd BUSY cycle abandons the operation.
    id_md_start = 1'b1;
    tick();
    clear_inputs();
    tick();
    #1;
    check_eq("rst_busy.pre", 32'(md_busy), 32'd1);
    rst = 1'b1;
    #1;
    check_ctl("rst_busy", 6'b0000_11);
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_busy.md_busy", 32'(md_busy), 32'd0);
    check_eq("rst_busy.stall_cnt", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check_eq($sformatf("abandon%0d.md_busy", i), 32'(md_busy), 32'd0);
      check_eq($sformatf("abandon%0d.md_done", i), 32'(md_done), 32'd0);
    end
    check_eq("abandon.stall_cnt", 32'(stall_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
